// File: rtl/fetch_if.sv
// Signal bundle between the fetch unit, the byte-wide instruction memory,
// the redirect source and the decode stage.
interface fetch_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_rdata;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             instr_valid;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: assembles 32-bit words from four byte reads and
// queues them with their PC in a small FIFO for the decode stage.
module fetch_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    fetch_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_byte_cnt;
    logic [23:0]      r_bytes;
    logic [WIDTH-1:0] r_fetch_pc;
    logic             r_mem_req;

    logic [WIDTH-1:0] r_fifo_instr [DEPTH];
    logic [WIDTH-1:0] r_fifo_pc    [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_slot_ok;
    logic [CW-1:0]    w_occ_after;
    logic [WIDTH-1:0] w_word;

    assign w_valid = (r_count != {CW{1'b0}}) && !reset;
    assign w_pop   = w_valid && bus.instr_ready;
    assign w_push  = (r_state == S_DRAIN) && !bus.redirect && !reset;
    assign w_word  = WIDTH'({bus.mem_rdata, r_bytes});

    // Occupancy once this cycle's pop and any DRAIN push have landed; a new word may start only below DEPTH.
    always_comb begin
        w_occ_after = r_count;
        if (r_state == S_DRAIN) begin
            w_occ_after = w_occ_after + CW'(1);
        end else begin
            w_occ_after = w_occ_after;
        end
        if (w_pop) begin
            w_occ_after = w_occ_after - CW'(1);
        end else begin
            w_occ_after = w_occ_after;
        end
    end

    assign w_slot_ok = (w_occ_after < CW'(DEPTH));

    // Fetch sequencer: byte issue, byte capture and fetch PC tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 2'd0;
            r_bytes    <= 24'd0;
            r_fetch_pc <= {WIDTH{1'b0}};
            r_mem_req  <= 1'b0;
        end else if (bus.redirect) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 2'd0;
            r_bytes    <= 24'd0;
            r_fetch_pc <= bus.redirect_pc & ~(WIDTH'(3));
            r_mem_req  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_byte_cnt <= 2'd0;
                    if (w_slot_ok) begin
                        r_state   <= S_ISSUE;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // Data for the byte issued last cycle arrives now.
                    case (r_byte_cnt)
                        2'd1:    r_bytes[7:0]   <= bus.mem_rdata;
                        2'd2:    r_bytes[15:8]  <= bus.mem_rdata;
                        2'd3:    r_bytes[23:16] <= bus.mem_rdata;
                        default: r_bytes        <= r_bytes;
                    endcase
                    if (r_byte_cnt == 2'd3) begin
                        r_state    <= S_DRAIN;
                        r_byte_cnt <= 2'd0;
                        r_mem_req  <= 1'b0;
                    end else begin
                        r_state    <= S_ISSUE;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_mem_req  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_fetch_pc <= r_fetch_pc + WIDTH'(4);
                    r_byte_cnt <= 2'd0;
                    if (w_slot_ok) begin
                        r_state   <= S_ISSUE;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_byte_cnt <= 2'd0;
                    r_mem_req  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect flushes and swallows a coincident pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (bus.redirect) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage, written on word completion.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= w_word;
            r_fifo_pc[r_wr_ptr]    <= r_fetch_pc;
        end
    end

    assign bus.mem_req     = r_mem_req && !bus.redirect && !reset;
    assign bus.mem_addr    = reset ? 8'd0 : (r_fetch_pc[7:0] + {6'd0, r_byte_cnt});
    assign bus.instr_valid = w_valid;
    assign bus.instr       = w_valid ? r_fifo_instr[r_rd_ptr] : {WIDTH{1'b0}};
    assign bus.instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr]    : {WIDTH{1'b0}};
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic clock;
    logic reset;
    fetch_if #(.WIDTH(32)) bus ();

    fetch_unit #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mem [256];
    logic        l_req  = 1'b0;
    logic [7:0]  l_addr = 8'd0;

    // reference model: fetch progress within a word, fetch PC, FIFO contents
    logic        m_busy = 1'b0;
    int          m_t    = 0;
    logic [31:0] m_pc   = 32'd0;
    logic        m_post = 1'b0;
    logic [63:0] q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [7:0] a0, a1, a2, a3;
        a0 = pc[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        return {mem[a3], mem[a2], mem[a1], mem[a0]};
    endfunction

    // memory answers one cycle after each request; otherwise drives noise
    initial begin : mem_resp
        bus.mem_rdata = 8'd0;
        forever begin
            @(posedge clock);
            #1;
            bus.mem_rdata = l_req ? mem[l_addr] : 8'($urandom);
        end
    end

    always @(negedge clock) begin : compare_proc
        logic        e_req;
        logic        e_valid;
        logic [63:0] head;
        logic [7:0]  e_addr;
        e_req   = !reset && m_busy && (m_t < 4) && !bus.redirect;
        e_valid = !reset && (q.size() > 0);
        head    = (q.size() > 0) ? q[0] : 64'd0;
        e_addr  = m_pc[7:0] + 8'(m_t);
        chk("mem_req", {63'd0, bus.mem_req}, {63'd0, e_req});
        chk("instr_valid", {63'd0, bus.instr_valid}, {63'd0, e_valid});
        if (reset || m_post) begin
            chk("rst_mem_addr", {56'd0, bus.mem_addr}, 64'd0);
            chk("rst_instr", {32'd0, bus.instr}, 64'd0);
            chk("rst_instr_pc", {32'd0, bus.instr_pc}, 64'd0);
        end else begin
            if (e_req) chk("mem_addr", {56'd0, bus.mem_addr}, {56'd0, e_addr});
            if (e_valid) begin
                chk("instr", {32'd0, bus.instr}, {32'd0, head[63:32]});
                chk("instr_pc", {32'd0, bus.instr_pc}, {32'd0, head[31:0]});
            end
        end
        l_req  = bus.mem_req;
        l_addr = bus.mem_addr;
        // advance model to next cycle using the inputs applied this cycle
        if (reset) begin
            q.delete();
            m_busy = 1'b0;
            m_t    = 0;
            m_pc   = 32'd0;
            m_post = 1'b1;
        end else begin
            m_post = 1'b0;
            if (bus.redirect) begin
                q.delete();
                m_busy = 1'b0;
                m_t    = 0;
                m_pc   = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if ((q.size() > 0) && bus.instr_ready) void'(q.pop_front());
                if (m_busy) begin
                    if (m_t == 4) begin
                        q.push_back({word_at(m_pc), m_pc});
                        m_pc   = m_pc + 32'd4;
                        m_t    = 0;
                        m_busy = (q.size() < DEPTH);
                    end else begin
                        m_t = m_t + 1;
                    end
                end else begin
                    m_busy = (q.size() < DEPTH);
                end
            end
        end
    end

    task automatic wait_req(input string name, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.mem_req && n < limit);
        if (!bus.mem_req) chk({name, "_req_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input string name, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.instr_valid && n < limit);
        if (!bus.instr_valid) chk({name, "_valid_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic drive_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin : main
        int n;
        int req_cnt;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'h00;
        reset = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.instr_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // basic fetch of the first word
        wait_req("t1", 20, n);
        chk("t1_addr0", {56'd0, bus.mem_addr}, 64'h00);
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            chk("t1_req", {63'd0, bus.mem_req}, 64'd1);
            chk("t1_addr", {56'd0, bus.mem_addr}, 64'(k));
        end
        wait_valid("t1", 20, n);
        chk("t1_latency", 64'(3 + n), 64'd5);
        chk("t1_instr", {32'd0, bus.instr}, 64'h00A00513);
        chk("t1_pc", {32'd0, bus.instr_pc}, 64'd0);

        // backpressure fills exactly DEPTH entries
        @(posedge clock); #1;
        bus.instr_ready = 1'b0;
        drive_reset();
        req_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k >= 25 && bus.mem_req) req_cnt++;
        end
        chk("t2_req_quiet", 64'(req_cnt), 64'd0);
        chk("t2_valid", {63'd0, bus.instr_valid}, 64'd1);
        @(posedge clock); #1;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("t2_pop_valid", {63'd0, bus.instr_valid}, 64'd1);
            chk("t2_pop_pc", {32'd0, bus.instr_pc}, 64'(4 * k));
        end
        @(negedge clock);
        chk("t2_drained", {63'd0, bus.instr_valid}, 64'd0);

        // redirect while byte 2 of the first word would issue
        drive_reset();
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(bus.mem_req && bus.mem_addr == 8'd1) && n < 20);
        chk("t3_saw_byte1", {63'd0, bus.mem_req}, 64'd1);
        @(posedge clock); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h43;
        @(negedge clock);
        chk("t3_req_low", {63'd0, bus.mem_req}, 64'd0);
        @(posedge clock); #1;
        bus.redirect = 1'b0;
        @(negedge clock);
        chk("t3_no_partial", {63'd0, bus.instr_valid}, 64'd0);
        wait_req("t3", 20, n);
        chk("t3_addr", {56'd0, bus.mem_addr}, 64'h40);
        wait_valid("t3", 20, n);
        chk("t3_pc", {32'd0, bus.instr_pc}, 64'h40);

        // address wrap at the top of the byte space
        @(posedge clock); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFC;
        @(posedge clock); #1;
        bus.redirect = 1'b0;
        wait_req("t4", 20, n);
        chk("t4_addr_fc", {56'd0, bus.mem_addr}, 64'hFC);
        for (int k = 1; k < 4; k++) begin
            @(negedge clock);
            chk("t4_addr", {56'd0, bus.mem_addr}, 64'(8'hFC + k));
        end
        @(negedge clock);
        chk("t4_drain_req", {63'd0, bus.mem_req}, 64'd0);
        @(negedge clock);
        chk("t4_addr_00", {56'd0, bus.mem_addr}, 64'h00);
        chk("t4_pc_fc", {32'd0, bus.instr_pc}, 64'hFC);
        wait_valid("t4", 20, n);
        chk("t4_pc_100", {32'd0, bus.instr_pc}, 64'h100);

        // reset during ISSUE with two words buffered
        @(posedge clock); #1;
        bus.instr_ready = 1'b0;
        drive_reset();
        wait_req("t5", 20, n);
        repeat (11) @(negedge clock);
        chk("t5_pre_valid", {63'd0, bus.instr_valid}, 64'd1);
        chk("t5_pre_req", {63'd0, bus.mem_req}, 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("t5_rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        chk("t5_rst_req", {63'd0, bus.mem_req}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t5_after_valid", {63'd0, bus.instr_valid}, 64'd0);
        wait_req("t5b", 20, n);
        chk("t5_restart_delay", 64'(n), 64'd1);
        chk("t5_restart_addr", {56'd0, bus.mem_addr}, 64'd0);

        // redirect with a coincident pop on a full FIFO
        repeat (40) @(negedge clock);
        @(posedge clock); #1;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        @(posedge clock); #1;
        bus.redirect = 1'b0;
        @(negedge clock);
        chk("t6_flushed", {63'd0, bus.instr_valid}, 64'd0);
        wait_valid("t6", 20, n);
        chk("t6_pc_first", {32'd0, bus.instr_pc}, 64'h80);
        wait_valid("t6b", 20, n);
        chk("t6_pc_second", {32'd0, bus.instr_pc}, 64'h84);

        // randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            reset           = ($urandom_range(0, 199) == 0);
            bus.redirect    = ($urandom_range(0, 29) == 0);
            bus.redirect_pc = $urandom;
            bus.instr_ready = (c % 400 < 80) ? ($urandom_range(0, 9) == 0)
                                             : ($urandom_range(0, 9) < 7);
        end
        @(posedge clock); #1;
        reset        = 1'b0;
        bus.redirect = 1'b0;
        repeat (5) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: instruction and PC width.
REQ-002 SHALL have parameter DEPTH, default 4: instruction FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port mem_req, output, 1: byte read request to instruction memory.
REQ-006 SHALL have port mem_addr, output, 8: byte address of request.
REQ-007 SHALL have port mem_rdata, input, 8: read byte, valid exactly one cycle after its mem_req.
REQ-008 SHALL have port redirect, input, 1: branch/jump taken, flush and refetch.
REQ-009 SHALL have port redirect_pc, input, WIDTH: new fetch PC.
REQ-010 SHALL have port instr_valid, output, 1: FIFO head holds a valid instruction.
REQ-011 SHALL have port instr, output, WIDTH: FIFO head instruction word.
REQ-012 SHALL have port instr_pc, output, WIDTH: PC of FIFO head instruction.
REQ-013 SHALL have port instr_ready, input, 1: decode accepts head this cycle.

Function
REQ-014 SHALL fetch each word as 4 byte reads, addresses fetch_pc[7:0]+0..+3 in order, one per cycle, wrapping mod 256.
REQ-015 SHALL assemble little-endian: byte at +0 -> instr[7:0], +3 -> instr[31:24].
REQ-016 SHALL use FSM states IDLE, ISSUE, DRAIN: IDLE -> ISSUE when a FIFO slot is reservable; ISSUE issues bytes 0..3 then -> DRAIN; DRAIN captures byte 3, pushes word, then -> ISSUE if a slot is reservable, else IDLE.
REQ-017 SHALL reserve a FIFO slot when leaving IDLE: start only if (occupancy + words in flight) < DEPTH, counting a same-cycle pop as freeing a slot.
REQ-018 SHALL keep mem_req low in IDLE and DRAIN, high in ISSUE unless redirect is high.
REQ-019 SHALL push {word, fetch_pc} on DRAIN completion, then advance fetch_pc by 4, wrapping mod 2^WIDTH.
REQ-020 SHALL give one word per 5 cycles steady state and first instr_valid 5 cycles after the first mem_req.
REQ-021 SHALL pop the head on instr_valid && instr_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-022 SHALL hold instr and instr_pc stable while instr_valid is high and instr_ready is low.
REQ-023 SHALL give redirect priority over all events: in that cycle flush FIFO, drop any in-flight byte and partial word, drive mem_req low, set fetch_pc <= {redirect_pc[WIDTH-1:2],2'b00}, and go to IDLE.
REQ-024 SHALL ignore a pop coinciding with redirect; instr_valid SHALL be low the cycle after redirect.
REQ-025 SHALL discard mem_rdata in the cycle after a redirect.
REQ-026 SHALL restart on back-to-back redirects from the latest redirect_pc only.

Reset
REQ-027 SHALL, on reset high at any edge (incl. mid-word): fetch_pc=0, FIFO empty, FSM=IDLE, partial word discarded.
REQ-028 SHALL drive during reset and in the cycle after: mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0.
REQ-029 SHALL have reset override redirect and instr_ready.

Verification
REQ-030 SHALL test basic fetch: memory bytes 0..3 = 13,05,A0,00, instr_ready=1 -> mem_addr 0,1,2,3, instr=0x00A00513, instr_pc=0, valid 5 cycles after first req.
REQ-031 SHALL test backpressure: instr_ready=0 for 40 cycles -> exactly DEPTH words buffered, mem_req low thereafter; release -> words popped in order, PCs 0,4,8,12.
REQ-032 SHALL test redirect mid-word: redirect_pc=0x43 while byte 2 issues -> next mem_addr 0x40, no partial word pushed, first new instr_pc=0x40.
REQ-033 SHALL test wrap: redirect_pc=0xFC -> mem_addr FC,FD,FE,FF then 00; instr_pc 0xFC then 0x100.
REQ-034 SHALL test reset mid-operation: reset during ISSUE with FIFO holding 2 words -> valid low, next fetch from addr 0.
REQ-035 SHALL test redirect with simultaneous pop on a full FIFO -> FIFO empty next cycle, no duplicate or lost redirect-target word.
